// File: rtl/slow_clk_mon_pkg.sv
// Shared types and default constants for the slow-clock edge monitor.
package slow_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        LOST = 2'd3
    } mon_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TIMEOUT     = 2**20;
    localparam int DEF_LOCK_EDGES  = 4;

endpackage

// File: rtl/slow_clk_edge_monitor_sync.sv
// Multi-flop metastability synchronizer for a single asynchronous bit; all stages reset to 0.
module sync_bit_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: non-blocking assignments make every stage capture the previous stage's old value.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/slow_clk_edge_monitor.sv
// Samples SLOW_CLK in the IN_CLK domain, emits rise/fall enables and tracks lock/loss.
// Optional period measurement enabled by defining SLOW_CLK_PERIOD_MEAS_EN.
module slow_clk_edge_monitor
    import slow_clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int LOCK_EDGES  = DEF_LOCK_EDGES
) (
    input  logic             IN_CLK,
    input  logic             RST_N,
    input  logic             SLOW_CLK,
    output logic             RISE_EN,
    output logic             FALL_EN,
    output logic             LOCKED,
    output logic             CLK_LOST,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID
);

    localparam int                EDGE_W           = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C        = CNT_W'(TIMEOUT);
    localparam logic [EDGE_W-1:0] LOCK_EDGES_C     = EDGE_W'(LOCK_EDGES);
    localparam mon_state_e        FIRST_RISE_STATE = (LOCK_EDGES == 1) ? LOCK : ACQ;

    logic             slow_sync;
    logic             hist_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             timeout;

    mon_state_e        state_q, state_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;

    logic rise_en_q, fall_en_q;
    logic locked_q, locked_d;
    logic lost_q, lost_d;

    sync_bit_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (IN_CLK),
        .rst_n_i (RST_N),
        .d_i     (SLOW_CLK),
        .q_o     (slow_sync)
    );

    assign rise = slow_sync & ~hist_q;
    assign fall = ~slow_sync & hist_q;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gap_d = gap_q;
        if (rise) begin
            gap_d = '0;
        end else if (gap_q != TIMEOUT_C) begin
            gap_d = gap_q + CNT_W'(1);
        end
    end

    // A rise landing on the saturated count wins over the timeout.
    assign timeout = (gap_q == TIMEOUT_C) & ~rise;

    always_ff @(posedge IN_CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        case (state_q)
            IDLE, LOST: begin
                if (rise) begin
                    edge_cnt_d = EDGE_W'(1);
                    state_d    = FIRST_RISE_STATE;
                end else if (timeout) begin
                    edge_cnt_d = '0;
                    state_d    = LOST;
                end
            end
            ACQ: begin
                if (rise) begin
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    if (edge_cnt_d == LOCK_EDGES_C) begin
                        state_d = LOCK;
                    end
                end else if (timeout) begin
                    edge_cnt_d = '0;
                    state_d    = LOST;
                end
            end
            LOCK: begin
                if (timeout) begin
                    edge_cnt_d = '0;
                    state_d    = LOST;
                end
            end
            default: begin
                edge_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_comb begin
        locked_d = (state_d == LOCK);
        lost_d   = (state_d == LOST);
    end

    always_ff @(posedge IN_CLK) begin
        if (!RST_N) begin
            hist_q    <= 1'b0;
            gap_q     <= '0;
            rise_en_q <= 1'b0;
            fall_en_q <= 1'b0;
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            hist_q    <= slow_sync;
            gap_q     <= gap_d;
            rise_en_q <= rise;
            fall_en_q <= fall;
            locked_q  <= locked_d;
            lost_q    <= lost_d;
        end
    end

    assign RISE_EN  = rise_en_q;
    assign FALL_EN  = fall_en_q;
    assign LOCKED   = locked_q;
    assign CLK_LOST = lost_q;

`ifdef SLOW_CLK_PERIOD_MEAS_EN
    logic [CNT_W-1:0] period_q, period_d;

    always_comb begin
        period_d = period_q;
        if (rise && (state_q == ACQ || state_q == LOCK)) begin
            period_d = (&gap_q) ? gap_q : gap_q + CNT_W'(1);
        end
    end

    // Holds the last measurement through LOST; only reset clears it.
    always_ff @(posedge IN_CLK) begin
        if (!RST_N) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign PERIOD       = period_q;
    assign PERIOD_VALID = locked_q;
`else
    assign PERIOD       = '0;
    assign PERIOD_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clk_edge_monitor.sv
// Bench for slow_clk_edge_monitor: directed scenarios plus random SLOW_CLK waveforms,
// compared every cycle against a cycle-count based model of the lock/loss rules.
module tb_slow_clk_edge_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 24;
    localparam int TIMEOUT     = 1000;
    localparam int LOCK_EDGES  = 4;
    localparam int MAX_EV      = 8192;
`ifdef SLOW_CLK_PERIOD_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic             IN_CLK   = 1'b0;
    logic             RST_N    = 1'b0;
    logic             SLOW_CLK = 1'b0;
    logic             RISE_EN, FALL_EN, LOCKED, CLK_LOST, PERIOD_VALID;
    logic [CNT_W-1:0] PERIOD;

    slow_clk_edge_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .LOCK_EDGES  (LOCK_EDGES)
    ) dut (
        .IN_CLK       (IN_CLK),
        .RST_N        (RST_N),
        .SLOW_CLK     (SLOW_CLK),
        .RISE_EN      (RISE_EN),
        .FALL_EN      (FALL_EN),
        .LOCKED       (LOCKED),
        .CLK_LOST     (CLK_LOST),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID)
    );

    always #5 IN_CLK = ~IN_CLK;

    int cyc   = 0;
    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the synchronizer is a pure delay; lock/loss follow from counting rises and
    // the number of cycles elapsed since the last rise (or reset).
    bit                 model_valid = 1'b0;
    logic [SYNC_STAGES:0] m_hist;
    bit                 m_rise, m_fall, m_lost;
    int                 m_nrise, ref_cyc, m_period, elapsed;

    always @(posedge IN_CLK) begin
        cyc++;
        if (!RST_N) begin
            m_hist      = '0;
            m_rise      = 1'b0;
            m_fall      = 1'b0;
            m_lost      = 1'b0;
            m_nrise     = 0;
            m_period    = 0;
            ref_cyc     = cyc;
            model_valid = 1'b1;
        end else begin
            m_rise  = m_hist[SYNC_STAGES-1] & ~m_hist[SYNC_STAGES];
            m_fall  = ~m_hist[SYNC_STAGES-1] & m_hist[SYNC_STAGES];
            m_hist  = {m_hist[SYNC_STAGES-1:0], SLOW_CLK};
            elapsed = cyc - 1 - ref_cyc;
            if (m_rise) begin
                if (!m_lost && m_nrise >= 1)
                    m_period = (cyc - ref_cyc > TIMEOUT + 1) ? TIMEOUT + 1 : cyc - ref_cyc;
                m_nrise = m_lost ? 1 : ((m_nrise >= LOCK_EDGES) ? LOCK_EDGES : m_nrise + 1);
                m_lost  = 1'b0;
                ref_cyc = cyc;
            end else if (elapsed >= TIMEOUT) begin
                m_lost  = 1'b1;
                m_nrise = 0;
            end
        end
    end

    always @(negedge IN_CLK) begin
        if (model_valid) begin
            check("rise_en",      RISE_EN,      m_rise);
            check("fall_en",      FALL_EN,      m_fall);
            check("locked",       LOCKED,       !m_lost && m_nrise >= LOCK_EDGES);
            check("clk_lost",     CLK_LOST,     m_lost);
            check("period",       PERIOD,       MEAS ? m_period : 0);
            check("period_valid", PERIOD_VALID, MEAS && !m_lost && m_nrise >= LOCK_EDGES);
        end
    end

    // Event log: cycle index of each output pulse or level change.
    int   rise_n = 0, fall_n = 0, lost_n = 0;
    int   rise_at [MAX_EV];
    int   fall_at [MAX_EV];
    int   lock_rise_cyc = -1, lock_fall_cyc = -1, lost_rise_cyc = -1, lost_fall_cyc = -1;
    logic prev_locked = 1'b0, prev_lost = 1'b0;

    always @(posedge IN_CLK) begin
        #1;
        if (RISE_EN === 1'b1) begin
            if (rise_n < MAX_EV) rise_at[rise_n] = cyc;
            rise_n++;
        end
        if (FALL_EN === 1'b1) begin
            if (fall_n < MAX_EV) fall_at[fall_n] = cyc;
            fall_n++;
        end
        if (LOCKED === 1'b1 && prev_locked !== 1'b1) lock_rise_cyc = cyc;
        if (LOCKED === 1'b0 && prev_locked === 1'b1) lock_fall_cyc = cyc;
        if (CLK_LOST === 1'b1 && prev_lost !== 1'b1) begin
            lost_rise_cyc = cyc;
            lost_n++;
        end
        if (CLK_LOST === 1'b0 && prev_lost === 1'b1) lost_fall_cyc = cyc;
        prev_locked = LOCKED;
        prev_lost   = CLK_LOST;
    end

    function automatic int rise_cyc(input int i);
        return (i >= 0 && i < MAX_EV && i < rise_n) ? rise_at[i] : -1;
    endfunction

    function automatic int fall_cyc(input int i);
        return (i >= 0 && i < MAX_EV && i < fall_n) ? fall_at[i] : -1;
    endfunction

    // Stimulus changes 2 time units after a rising edge and stays for n sampling edges.
    task automatic phase(input logic v, input int n);
        SLOW_CLK = v;
        repeat (n) @(posedge IN_CLK);
        #2;
    endtask

    task automatic square(input int hi, input int lo, input int k);
        repeat (k) begin
            phase(1'b1, hi);
            phase(1'b0, lo);
        end
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        @(posedge IN_CLK);
        #2;
        RST_N = 1'b1;
    endtask

    int t0, r0, f0, l0, sel;

    initial begin
        repeat (3) @(posedge IN_CLK);
        #2;
        RST_N = 1'b1;

        // Steady 40-cycle wave: latency, pulse spacing, lock on the 4th rise.
        phase(1'b0, 10);
        t0 = cyc; r0 = rise_n; f0 = fall_n;
        square(20, 20, 6);
        check("t1_first_rise_latency", rise_cyc(r0) - t0, 3);
        check("t1_rise_to_fall", fall_cyc(f0) - rise_cyc(r0), 20);
        check("t1_rise_to_rise", rise_cyc(r0 + 1) - rise_cyc(r0), 40);
        check("t1_lock_with_4th_rise", lock_rise_cyc, rise_cyc(r0 + 3));
        check("t1_locked", LOCKED, 1);

        // Period measurement 40 then 64.
        check("t2_period_40", PERIOD, MEAS ? 40 : 0);
        check("t2_period_valid", PERIOD_VALID, MEAS ? 1 : 0);
        phase(1'b1, 32);
        phase(1'b0, 32);
        check("t2_period_before_long", PERIOD, MEAS ? 40 : 0);
        phase(1'b1, 5);
        check("t2_period_64", PERIOD, MEAS ? 64 : 0);
        phase(1'b1, 27);
        phase(1'b0, 32);
        square(32, 32, 1);
        check("t2_period_64_again", PERIOD, MEAS ? 64 : 0);

        // Clock stops low, then restarts.
        phase(1'b0, 1100);
        check("t3_lost_latency", lost_rise_cyc - rise_cyc(rise_n - 1), 1001);
        check("t3_locked_drops_with_lost", lock_fall_cyc, lost_rise_cyc);
        check("t3_clk_lost", CLK_LOST, 1);
        r0 = rise_n;
        square(20, 20, 5);
        check("t3_lost_clears_first_rise", lost_fall_cyc, rise_cyc(r0));
        check("t3_relock_4th_rise", lock_rise_cyc, rise_cyc(r0 + 3));

        // Rise exactly on the saturated gap is in time; one cycle later is not.
        l0 = lost_n;
        phase(1'b1, 20);
        phase(1'b0, 981);
        phase(1'b1, 20);
        check("t4_spacing_1001", rise_cyc(rise_n - 1) - rise_cyc(rise_n - 2), 1001);
        check("t4_no_lost_at_timeout", lost_n, l0);
        check("t4_still_locked", LOCKED, 1);
        check("t4_period_1001", PERIOD, MEAS ? 1001 : 0);
        phase(1'b0, 982);
        phase(1'b1, 20);
        check("t4_lost_one_late", lost_n, l0 + 1);
        check("t4_lost_cleared", CLK_LOST, 0);

        // Reset while locked in the middle of a high phase.
        phase(1'b0, 20);
        square(20, 20, 4);
        phase(1'b1, 10);
        check("t5_locked_before_reset", LOCKED, 1);
        f0 = fall_n; r0 = rise_n;
        pulse_reset();
        check("t5_rst_rise_en", RISE_EN, 0);
        check("t5_rst_fall_en", FALL_EN, 0);
        check("t5_rst_locked", LOCKED, 0);
        check("t5_rst_clk_lost", CLK_LOST, 0);
        check("t5_rst_period", PERIOD, 0);
        check("t5_rst_period_valid", PERIOD_VALID, 0);
        phase(1'b1, 10);
        check("t5_no_spurious_fall", fall_n, f0);
        phase(1'b0, 20);
        square(20, 20, 3);
        check("t5_relock_4th_rise", lock_rise_cyc, rise_cyc(r0 + 3));
        check("t5_relocked", LOCKED, 1);

        // SLOW_CLK stuck low from reset.
        RST_N = 1'b0;
        SLOW_CLK = 1'b0;
        repeat (3) @(posedge IN_CLK);
        #2;
        t0 = cyc; r0 = rise_n; f0 = fall_n;
        RST_N = 1'b1;
        phase(1'b0, 1100);
        check("t6_lost_latency", lost_rise_cyc - t0, 1001);
        check("t6_no_rise_en", rise_n, r0);
        check("t6_no_fall_en", fall_n, f0);

        // Random waveforms, long holds near the timeout, and occasional resets.
        pulse_reset();
        phase(SLOW_CLK, 4);
        for (int seg = 0; seg < 60; seg++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0) begin
                pulse_reset();
                phase(SLOW_CLK, 4);
            end else if (sel == 1) begin
                phase(SLOW_CLK, $urandom_range(950, 1050));
            end else begin
                square($urandom_range(3, 40), $urandom_range(3, 40), $urandom_range(1, 8));
            end
        end

        repeat (5) @(posedge IN_CLK);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
